// File: rtl/chrono_pkg.sv
// Shared time type and 6-digit packed-BCD helpers for the lap stopwatch.
// Digits are packed {min1,min0,sec1,sec0,hnd1,hnd0}, least significant nibble first in loops.
package chrono_pkg;

   typedef logic [23:0] time_t;

   // Per-digit maximum, same packing as time_t: 5,9 : 5,9 . 9,9
   localparam time_t DIG_LIM = 24'h595999;

   function automatic time_t bcd_inc(input time_t t);
      time_t r;
      logic  c;
      r = t;
      c = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (c) begin
            if (t[4*i +: 4] >= DIG_LIM[4*i +: 4]) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = t[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic time_t bcd_dec(input time_t t);
      time_t r;
      logic  b;
      r = t;
      b = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (b) begin
            if (t[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = DIG_LIM[4*i +: 4];
            end else begin
               r[4*i +: 4] = t[4*i +: 4] - 4'd1;
               b = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic time_t bcd_clamp(input time_t t);
      time_t r;
      for (int i = 0; i < 6; i++)
         r[4*i +: 4] = (t[4*i +: 4] > DIG_LIM[4*i +: 4]) ? DIG_LIM[4*i +: 4] : t[4*i +: 4];
      return r;
   endfunction

endpackage

// File: rtl/lap_fifo.sv
// Ring buffer of lap times with registered show-ahead head; a push into a full
// buffer drops the oldest entry and sets a sticky overflow flag.
module lap_fifo
   import chrono_pkg::*;
#(
   parameter int LAPN = 8,
   parameter int LAPL = $clog2(LAPN)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  time_t         din,
   output time_t         dat,
   output logic          vld,
   output logic [LAPL:0] cnt,
   output logic          ovf
);

   localparam logic [LAPL:0]   FULL = (LAPL+1)'(LAPN);
   localparam logic [LAPL:0]   C1   = (LAPL+1)'(1);
   localparam logic [LAPL-1:0] P1   = LAPL'(1);

   time_t           r_mem [LAPN];
   logic [LAPL-1:0] r_wp, r_rp, w_rp_n;
   logic [LAPL:0]   r_cnt, w_cnt_n;
   logic            w_pop, w_full;
   time_t           r_dat;
   logic            r_vld, r_ovf;

   always_comb begin
      w_pop   = pop & (r_cnt != '0);
      w_full  = (r_cnt == FULL);
      w_rp_n  = r_rp;
      w_cnt_n = r_cnt;
      if (w_pop || (push && w_full))
         w_rp_n = r_rp + P1;
      if (push && !w_pop && !w_full)
         w_cnt_n = r_cnt + C1;
      else if (w_pop && !push)
         w_cnt_n = r_cnt - C1;
   end

   always_ff @(posedge clk)
      if (push) r_mem[r_wp] <= din;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
         r_dat <= '0;
         r_vld <= 1'b0;
      end else if (flush) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
         r_dat <= '0;
         r_vld <= 1'b0;
      end else begin
         if (push) r_wp <= r_wp + P1;
         r_rp  <= w_rp_n;
         r_cnt <= w_cnt_n;
         if (push && w_full && !w_pop) r_ovf <= 1'b1;
         r_vld <= (w_cnt_n != '0);
         // New head may be the entry being written this same edge
         if (w_cnt_n == '0)
            r_dat <= '0;
         else if (push && (w_rp_n == r_wp))
            r_dat <= din;
         else
            r_dat <= r_mem[w_rp_n];
      end
   end

   assign dat = r_dat;
   assign vld = r_vld;
   assign cnt = r_cnt;
   assign ovf = r_ovf;

endmodule

// File: rtl/chrono_lap.sv
// BCD stopwatch with up/down counting, countdown alarm, tick divider and lap buffer.
// All button events are rising edges evaluated against pre-edge state.
module chrono_lap
   import chrono_pkg::*;
#(
   parameter int TPN  = 1024,
   parameter int TPL  = $clog2(TPN),
   parameter int LAPN = 8,
   parameter int LAPL = $clog2(LAPN)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          b_run,
   input  logic          b_clr,
   input  logic          b_lap,
   input  logic          mode,
   input  time_t         pre_time,
   input  logic          lap_rd,
   output time_t         t_time,
   output time_t         lap_dat,
   output logic          lap_vld,
   output logic [LAPL:0] lap_cnt,
   output logic          lap_ovf,
   output logic          s_run,
   output logic          s_alm
);

   localparam logic [TPL-1:0] DIV_TOP = TPL'(TPN - 1);

   logic           r_run_d, r_clr_d, r_lap_d;
   logic           w_run_p, w_clr_p, w_lap_p;
   logic [TPL-1:0] r_div;
   logic           r_tick, r_run, r_dn, r_alm;
   time_t          r_time, w_inc, w_dec;
   logic           w_cnt_en, w_zero, w_load, w_start_ok;

   always_comb begin
      w_run_p    = b_run & ~r_run_d;
      w_clr_p    = b_clr & ~r_clr_d;
      w_lap_p    = b_lap & ~r_lap_d;
      w_inc      = bcd_inc(r_time);
      w_dec      = bcd_dec(r_time);
      w_cnt_en   = r_tick & r_run;
      w_zero     = w_cnt_en & r_dn & (w_dec == '0);
      w_load     = w_clr_p & ~r_run;
      // Start check sees the time before any same-edge load
      w_start_ok = ~(mode & (r_time == '0));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_run_d <= 1'b0;
         r_clr_d <= 1'b0;
         r_lap_d <= 1'b0;
         r_div   <= '0;
         r_tick  <= 1'b0;
         r_run   <= 1'b0;
         r_dn    <= 1'b0;
         r_alm   <= 1'b0;
         r_time  <= '0;
      end else begin
         r_run_d <= b_run;
         r_clr_d <= b_clr;
         r_lap_d <= b_lap;
         if (!r_run || r_div == DIV_TOP) r_div <= '0;
         else                             r_div <= r_div + TPL'(1);
         r_tick <= r_run & (r_div == DIV_TOP);

         if (w_zero) begin
            r_run <= 1'b0;
         end else if (w_run_p) begin
            if (r_run) begin
               r_run <= 1'b0;
            end else if (w_start_ok) begin
               r_run <= 1'b1;
               r_dn  <= mode;
            end
         end

         if (w_zero)                 r_alm <= 1'b1;
         else if (w_run_p | w_clr_p) r_alm <= 1'b0;

         if (w_load)        r_time <= mode ? bcd_clamp(pre_time) : '0;
         else if (w_cnt_en) r_time <= r_dn ? w_dec : w_inc;
      end
   end

   lap_fifo #(.LAPN(LAPN), .LAPL(LAPL)) u_lap (
      .clk   (clk),
      .rst   (rst),
      .push  (w_lap_p & r_run),
      .pop   (lap_rd),
      .flush (w_load),
      .din   (r_time),
      .dat   (lap_dat),
      .vld   (lap_vld),
      .cnt   (lap_cnt),
      .ovf   (lap_ovf)
   );

   assign t_time = r_time;
   assign s_run  = r_run;
   assign s_alm  = r_alm;

endmodule

// File: tb/tb_chrono_lap.sv
// Bench for chrono_lap: centisecond-integer reference model with a lap queue,
// per-cycle monitor against the model, plus directed scenario checks.
module tb_chrono_lap;

   localparam int TPN  = 4;
   localparam int LAPN = 4;
   localparam int LAPL = $clog2(LAPN);
   localparam int DAY  = 360000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          b_run = 0, b_clr = 0, b_lap = 0, mode = 0, lap_rd = 0;
   logic [23:0]   pre_time = '0;
   logic [23:0]   t_time, lap_dat;
   logic          lap_vld, lap_ovf, s_run, s_alm;
   logic [LAPL:0] lap_cnt;

   int errors = 0;
   int checks = 0;

   chrono_lap #(.TPN(TPN), .LAPN(LAPN)) dut (
      .clk(clk), .rst(rst), .b_run(b_run), .b_clr(b_clr), .b_lap(b_lap),
      .mode(mode), .pre_time(pre_time), .lap_rd(lap_rd),
      .t_time(t_time), .lap_dat(lap_dat), .lap_vld(lap_vld), .lap_cnt(lap_cnt),
      .lap_ovf(lap_ovf), .s_run(s_run), .s_alm(s_alm)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] to_bcd(input int cs);
      int mn, sc, h;
      mn = cs / 6000;
      sc = (cs / 100) % 60;
      h  = cs % 100;
      return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10), 4'(h / 10), 4'(h % 10)};
   endfunction

   function automatic int clamp_cs(input logic [23:0] p);
      int lim [6] = '{9, 9, 9, 5, 9, 5};
      int wgt [6] = '{1, 10, 100, 1000, 6000, 60000};
      int s, d;
      s = 0;
      for (int i = 0; i < 6; i++) begin
         d = int'(p[4*i +: 4]);
         if (d > lim[i]) d = lim[i];
         s += d * wgt[i];
      end
      return s;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: time kept as centiseconds, laps as a queue of expected entries
   int          m_t = 0, m_m = 0;
   bit          m_run = 0, m_alm = 0, m_dn = 0, m_ovf = 0;
   bit          pb_r = 0, pb_c = 0, pb_l = 0;
   logic [23:0] q[$];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_t = 0; m_m = 0; m_run = 0; m_alm = 0; m_dn = 0; m_ovf = 0;
         pb_r = 0; pb_c = 0; pb_l = 0;
         q.delete();
      end else begin
         bit rp, cp, lp, run0, tk;
         int t0;
         rp = b_run && !pb_r;
         cp = b_clr && !pb_c;
         lp = b_lap && !pb_l;
         pb_r = b_run; pb_c = b_clr; pb_l = b_lap;
         t0 = m_t;
         run0 = m_run;
         tk = run0 && (m_m > 0) && (m_m % TPN == 0);
         if (run0) m_m++;
         if (lap_rd && q.size() > 0) void'(q.pop_front());
         if (lp && run0) begin
            q.push_back(to_bcd(t0));
            if (q.size() > LAPN) begin
               void'(q.pop_front());
               m_ovf = 1;
            end
         end
         if (rp || cp) m_alm = 0;
         if (rp) begin
            if (run0) m_run = 0;
            else if (!(mode && t0 == 0)) begin
               m_run = 1; m_dn = mode; m_m = 0;
            end
         end
         if (cp && !run0) begin
            m_t = mode ? clamp_cs(pre_time) : 0;
            q.delete();
            m_ovf = 0;
         end else if (tk) begin
            if (m_dn) begin
               m_t = (t0 + DAY - 1) % DAY;
               if (m_t == 0) begin m_run = 0; m_alm = 1; end
            end else begin
               m_t = (t0 + 1) % DAY;
            end
         end
      end
   end

   // Monitor: every cycle compare outputs to the model; head of lap queue while valid
   always @(negedge clk) begin
      #1;
      chk("state", {t_time, s_run, s_alm, lap_cnt, lap_ovf, lap_vld},
          {to_bcd(m_t), m_run, m_alm, 3'(q.size()), m_ovf, q.size() > 0});
      if (lap_vld && q.size() > 0) chk("lap_dat", lap_dat, q[0]);
   end

   task automatic press(input int which);
      case (which)
         0: b_run = 1;
         1: b_clr = 1;
         default: b_lap = 1;
      endcase
      @(negedge clk);
      b_run = 0; b_clr = 0; b_lap = 0;
   endtask

   logic [23:0] cap [6];

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_out", {t_time, lap_dat, lap_vld, lap_cnt, lap_ovf, s_run, s_alm}, '0);
      rst = 0;
      @(negedge clk);

      // Count up for one minute, checking the tick edge exactly
      mode = 0;
      press(1);
      press(0);
      repeat (24000) @(negedge clk);
      chk("up_5999", t_time, 24'h005999);
      @(negedge clk);
      chk("up_1min", t_time, 24'h010000);
      press(0);

      // Wrap at 59:59.99 without alarm
      mode = 1; pre_time = 24'h595995;
      press(1);
      chk("load_595995", t_time, 24'h595995);
      mode = 0;
      press(0);
      repeat (21) @(negedge clk);
      chk("wrap_time", t_time, 24'h000000);
      chk("wrap_flags", {s_run, s_alm}, 2'b10);
      press(0);

      // Countdown to zero alarm, refused restart clears alarm
      mode = 1; pre_time = 24'h000005;
      press(1);
      chk("load_5", t_time, 24'h000005);
      press(0);
      repeat (21) @(negedge clk);
      chk("dn_time", t_time, 24'h000000);
      chk("dn_flags", {s_run, s_alm}, 2'b01);
      press(0);
      chk("dn_refuse", {s_run, s_alm}, 2'b00);

      // Clamp on load
      pre_time = 24'h7A6CFF;
      press(1);
      chk("clamp", t_time, 24'h595999);

      // Six laps into a four-deep buffer
      mode = 0;
      press(1);
      press(0);
      for (int i = 0; i < 6; i++) begin
         cap[i] = to_bcd(m_t);
         press(2);
         repeat (3) @(negedge clk);
      end
      chk("ovf_cnt", {lap_cnt, lap_ovf}, {3'd4, 1'b1});
      chk("ovf_head", lap_dat, cap[2]);
      press(0);
      lap_rd = 1;
      repeat (4) @(negedge clk);
      lap_rd = 0;
      chk("drained", {lap_vld, lap_cnt}, 4'b0000);

      // Push and pop together while full
      press(1);
      chk("flush1", {lap_cnt, lap_ovf}, 4'b0000);
      press(0);
      for (int i = 0; i < 4; i++) begin
         cap[i] = to_bcd(m_t);
         press(2);
         repeat (2) @(negedge clk);
      end
      chk("full4", {lap_cnt, lap_ovf}, {3'd4, 1'b0});
      b_lap = 1; lap_rd = 1;
      @(negedge clk);
      b_lap = 0; lap_rd = 0;
      chk("pushpop_cnt", {lap_cnt, lap_ovf}, {3'd4, 1'b0});
      chk("pushpop_head", lap_dat, cap[1]);
      press(0);
      press(1);
      chk("flush2", {lap_cnt, lap_ovf}, 4'b0000);

      // Reset mid-count with laps held, then first tick timing after restart
      press(0);
      for (int i = 0; i < 3; i++) begin
         press(2);
         repeat (2) @(negedge clk);
      end
      repeat (7) @(negedge clk);
      rst = 1;
      #1;
      chk("midrst", {t_time, lap_dat, lap_vld, lap_cnt, lap_ovf, s_run, s_alm}, '0);
      @(negedge clk);
      rst = 0;
      press(0);
      repeat (TPN) @(negedge clk);
      chk("restart_pre", t_time, 24'h000000);
      @(negedge clk);
      chk("restart_tick", t_time, 24'h000001);

      // Random button traffic against the model
      for (int i = 0; i < 3000; i++) begin
         b_run  = ($urandom_range(0, 39) == 0);
         b_clr  = ($urandom_range(0, 29) == 0);
         b_lap  = ($urandom_range(0, 7) == 0);
         lap_rd = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 49) == 0) mode = ~mode;
         if ($urandom_range(0, 99) == 0) pre_time = 24'($urandom);
         @(negedge clk);
      end
      b_run = 0; b_clr = 0; b_lap = 0; lap_rd = 0;
      repeat (3) @(negedge clk);
      #2;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
